hazard_scoreboard: RTL and testbench

//  Parametrised, stateful successor to the combinational ID-stage hazard check. It keeps a per-register

---
 rtl/hazard_scoreboard.sv | 109 ++++++++++
 tb/tb_hazard_scoreboard.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Stateful ID-stage hazard check. It keeps one countdown per architectural
//   register. The countdown gives the number of cycles until the in-flight
//   result for that register can be used. ID is stalled whenever a source
//   operand is still too far away. Branches compare in ID and need the value
//   fully resolved. Other consumers can take it through forwarding once the
//   count has dropped to ALU_LAT.
//
// Ports
//   clk, rst_n       clock (rising edge) and asynchronous active-low reset
//   id_valid         valid instruction in ID
//   id_rs, id_rt     source addresses (rt only counts when id_use_rt=1)
//   id_use_rt        rt is a real source operand
//   id_is_branch     BEQ/BNE resolved in ID
//   id_wb_en         instruction writes the register file
//   id_mem_read      instruction is a load
//   id_dest          destination register
//   flush            ID instruction squashed this cycle
//   hazard_detected  stall IF/ID and bubble EXE (combinational)
//   pending          bit r set while register r has a result in flight
//   stall_count      saturating count of stalled cycles
module hazard_scoreboard #(
  parameter int REG_FILE_ADDR_LEN = 5,
  parameter int ALU_LAT           = 2,
  parameter int MEM_LAT           = 1,
  parameter int STALL_CNT_W       = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          id_valid,
  input  logic [REG_FILE_ADDR_LEN-1:0]  id_rs,
  input  logic [REG_FILE_ADDR_LEN-1:0]  id_rt,
  input  logic                          id_use_rt,
  input  logic                          id_is_branch,
  input  logic                          id_wb_en,
  input  logic                          id_mem_read,
  input  logic [REG_FILE_ADDR_LEN-1:0]  id_dest,
  input  logic                          flush,
  output logic                          hazard_detected,
  output logic [(2**REG_FILE_ADDR_LEN)-1:0] pending,
  output logic [STALL_CNT_W-1:0]        stall_count
);

  localparam int NREG     = 2**REG_FILE_ADDR_LEN;
  localparam int LOAD_LAT = ALU_LAT + MEM_LAT;
  localparam int CNT_W    = $clog2(LOAD_LAT + 1);

  localparam logic [CNT_W-1:0] ALU_CNT  = CNT_W'(ALU_LAT);
  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_LAT);

  logic [CNT_W-1:0] cnt [NREG];
  logic [CNT_W-1:0] thr;
  logic             src_busy;
  logic             issue;

  // A branch needs the value fully resolved (count 0). Any other consumer can
  // forward once the producer is within ALU_LAT of completion. Register 0 is
  // never checked, because it is hard-wired to zero.
  always_comb begin
    src_busy = 1'b0;
    thr      = id_is_branch ? '0 : ALU_CNT;
    for (int s = 1; s < NREG; s++) begin
      if ((id_rs == REG_FILE_ADDR_LEN'(s) ||
           (id_use_rt && id_rt == REG_FILE_ADDR_LEN'(s))) &&
          (cnt[s] > thr)) begin
        src_busy = 1'b1;
      end
    end
  end

  assign hazard_detected = id_valid & ~flush & src_busy;
  assign issue           = id_valid & ~flush & ~hazard_detected;

  // Countdown per register. An issuing writer reloads its destination, and it
  // takes priority over the decrement. The newest writer wins because writes
  // retire in order. The hazard check above reads the pre-update count, so a
  // self-dependency sees the older producer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (r == 0) begin
          cnt[r] <= '0;
        end else if (issue && id_wb_en && id_dest == REG_FILE_ADDR_LEN'(r)) begin
          cnt[r] <= id_mem_read ? LOAD_CNT : ALU_CNT;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - CNT_W'(1);
        end
      end
    end
  end

  // A pending bit is derived straight from the count, so it clears as soon as
  // reset is asserted.
  always_comb begin
    for (int r = 0; r < NREG; r++) pending[r] = (cnt[r] != '0);
  end

  // Performance counter of stalled cycles. It holds at all-ones when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (hazard_detected && stall_count != '1) begin
      stall_count <= stall_count + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
//   Directed bench for hazard_scoreboard. A default instance (ALU_LAT=2,
//   MEM_LAT=1) carries most of the checks. A second instance with MEM_LAT=3
//   shares the same stimulus and checks the longer load-to-branch latency.
module tb_hazard_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rt;
  logic        id_is_branch;
  logic        id_wb_en;
  logic        id_mem_read;
  logic [4:0]  id_dest;
  logic        flush;
  logic        hazard_detected;
  logic [31:0] pending;
  logic [31:0] stall_count;
  logic        hazard_detected_m3;
  logic [31:0] pending_m3;
  logic [31:0] stall_count_m3;

  int testsRun    = 0;
  int testsFailed = 0;
  int stalls;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rt(id_use_rt), .id_is_branch(id_is_branch), .id_wb_en(id_wb_en),
    .id_mem_read(id_mem_read), .id_dest(id_dest), .flush(flush),
    .hazard_detected(hazard_detected), .pending(pending), .stall_count(stall_count)
  );

  hazard_scoreboard #(.MEM_LAT(3)) dut_m3 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rt(id_use_rt), .id_is_branch(id_is_branch), .id_wb_en(id_wb_en),
    .id_mem_read(id_mem_read), .id_dest(id_dest), .flush(flush),
    .hazard_detected(hazard_detected_m3), .pending(pending_m3),
    .stall_count(stall_count_m3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value against its expected value and tallies it.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Drives every ID input. It is called just after a falling edge and lets the
  // combinational outputs settle before returning.
  task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                               input logic use_rt, input logic br, input logic wb,
                               input logic mr, input logic [4:0] dest, input logic fl);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rt = use_rt; id_is_branch = br;
    id_wb_en = wb; id_mem_read = mr; id_dest = dest; flush = fl;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) step();
  endtask

  // Counts the cycles that the selected instance holds the current ID
  // instruction. The count is bounded so that a stuck hazard cannot hang the run.
  task automatic countStalls(input bit use_m3, output int n);
    n = 0;
    while ((use_m3 ? hazard_detected_m3 : hazard_detected) && n < 20) begin
      step();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(1, 3, 3, 1, 1, 1, 1, 3, 0);
    #10;
    checkOutput("reset_hazard", hazard_detected, 0);
    checkOutput("reset_pending", pending, 0);
    checkOutput("reset_stall_count", stall_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drain(2);

    // ALU producer followed by an ALU consumer: forwarding covers it
    applyStimulus(1, 1, 2, 1, 0, 1, 0, 3, 0);
    checkOutput("t1_add_r3_hazard", hazard_detected, 0);
    step();
    applyStimulus(1, 3, 5, 1, 0, 1, 0, 4, 0);
    checkOutput("t1_use_r3_hazard", hazard_detected, 0);
    checkOutput("t1_pending3_c1", pending[3], 1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t1_pending3_c2", pending[3], 1);
    step();
    checkOutput("t1_pending3_c3", pending[3], 0);
    drain(4);

    // load followed by use: one stall
    applyStimulus(1, 1, 0, 0, 0, 1, 1, 3, 0);
    step();
    applyStimulus(1, 3, 5, 1, 0, 1, 0, 4, 0);
    checkOutput("t2_load_use_hazard", hazard_detected, 1);
    step();
    checkOutput("t2_after_stall_hazard", hazard_detected, 0);
    checkOutput("t2_stall_count", stall_count, 1);
    step();
    drain(5);

    // ALU result feeding a branch: two stalls
    applyStimulus(1, 1, 2, 1, 0, 1, 0, 5, 0);
    step();
    applyStimulus(1, 5, 6, 1, 1, 0, 0, 0, 0);
    countStalls(0, stalls);
    checkOutput("t3_alu_branch_stalls", stalls, 2);
    step();
    checkOutput("t3_stall_count_a", stall_count, 3);
    drain(5);

    // load result feeding a branch: three stalls
    applyStimulus(1, 1, 0, 0, 0, 1, 1, 5, 0);
    step();
    applyStimulus(1, 5, 6, 1, 1, 0, 0, 0, 0);
    countStalls(0, stalls);
    checkOutput("t3_load_branch_stalls", stalls, 3);
    step();
    checkOutput("t3_stall_count_b", stall_count, 6);
    drain(6);

    // a load into r0 is never tracked
    applyStimulus(1, 1, 0, 0, 0, 1, 1, 0, 0);
    step();
    checkOutput("t4_pending0", pending[0], 0);
    applyStimulus(1, 0, 0, 1, 1, 1, 0, 1, 0);
    checkOutput("t4_r0_branch_hazard", hazard_detected, 0);
    step();
    drain(4);

    // rt is only a source when id_use_rt is set
    applyStimulus(1, 1, 0, 0, 0, 1, 1, 3, 0);
    step();
    applyStimulus(1, 2, 3, 1, 0, 1, 0, 7, 0);
    checkOutput("t4_rt_used_hazard", hazard_detected, 1);
    applyStimulus(1, 2, 3, 0, 0, 1, 0, 7, 0);
    checkOutput("t4_rt_unused_hazard", hazard_detected, 0);
    step();
    drain(5);

    // flushing a stalled consumer: no hazard and no scoreboard write
    applyStimulus(1, 1, 0, 0, 0, 1, 1, 3, 0);
    step();
    applyStimulus(1, 3, 5, 1, 0, 1, 0, 4, 0);
    checkOutput("t5_before_flush_hazard", hazard_detected, 1);
    applyStimulus(1, 3, 5, 1, 0, 1, 0, 4, 1);
    checkOutput("t5_flush_hazard", hazard_detected, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t5_pending4_after_flush", pending[4], 0);
    checkOutput("t5_pending3_c1", pending[3], 1);
    step();
    checkOutput("t5_pending3_c2", pending[3], 1);
    step();
    checkOutput("t5_pending3_c3", pending[3], 0);
    checkOutput("t5_stall_count", stall_count, 6);
    drain(4);

    // asynchronous reset in the middle of a branch stall
    applyStimulus(1, 1, 0, 0, 0, 1, 1, 3, 0);
    step();
    applyStimulus(1, 3, 6, 1, 1, 0, 0, 0, 0);
    checkOutput("t6_stall_c1", hazard_detected, 1);
    step();
    checkOutput("t6_stall_c2", hazard_detected, 1);
    checkOutput("t6_stall_count_pre", stall_count, 7);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_async_hazard", hazard_detected, 0);
    checkOutput("t6_async_pending", pending, 0);
    checkOutput("t6_async_stall_count", stall_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("t6_post_reset_hazard", hazard_detected, 0);
    step();
    checkOutput("t6_post_reset_stall_count", stall_count, 0);
    drain(8);

    // longer memory latency: load to branch takes five stalls
    applyStimulus(1, 1, 0, 0, 0, 1, 1, 5, 0);
    step();
    checkOutput("t3_m3_pending5", pending_m3[5], 1);
    applyStimulus(1, 5, 6, 1, 1, 0, 0, 0, 0);
    countStalls(1, stalls);
    checkOutput("t3_m3_load_branch_stalls", stalls, 5);
    drain(2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
